divider: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage. Computes quotient and remainder of signed or unsigned operands with a restoring shift-subtract algorithm, one quotient bit per clock. Exchanges operands and results with the pipeline control through a start/done handshake. Division-by-zero and signed-overflow results follow RISC-V M-extension semantics.

---
 rtl/divider_pkg.sv | 13 +
 rtl/divider_if.sv | 26 ++
 rtl/divider_step.sv | 29 ++
 rtl/divider.sv | 131 +++++++++++++
 tb/tb_divider.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// Shared constants for the multi-cycle divider: default width, counter
// width and the FSM state encoding.
package divider_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int CNT_W_DEF   = $clog2(NB_DATA_DEF);

    // FSM states kept as plain constants so older tooling can decode them.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;

endpackage

// File: rtl/divider_if.sv
// Start/done handshake between pipeline control (master) and the divider
// (slave). Operands travel with i_start; results are held until the next
// o_done pulse.
interface divider_if #(
    parameter int NB_DATA = divider_pkg::NB_DATA_DEF
);
    logic               i_start;
    logic               i_signed;
    logic [NB_DATA-1:0] i_dividend;
    logic [NB_DATA-1:0] i_divisor;
    logic               o_busy;
    logic               o_done;
    logic [NB_DATA-1:0] o_quotient;
    logic [NB_DATA-1:0] o_remainder;
    logic               o_div_by_zero;

    modport master (
        output i_start, i_signed, i_dividend, i_divisor,
        input  o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );

    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor,
        output o_busy, o_done, o_quotient, o_remainder, o_div_by_zero
    );
endinterface

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift {remainder, dividend} left,
// trial-subtract the divisor and shift the resulting quotient bit into the
// low end of the dividend register.
module divider_step
    import divider_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic [NB_DATA-1:0] rem_in,
    input  logic [NB_DATA-1:0] dvd_in,
    input  logic [NB_DATA-1:0] dsr_in,
    output logic [NB_DATA-1:0] rem_out,
    output logic [NB_DATA-1:0] dvd_out
);
    logic [NB_DATA:0]   shifted;
    logic [NB_DATA-1:0] diff;
    logic               borrow;

    // The shifted remainder is NB_DATA+1 bits wide; the borrow of that wide
    // subtraction decides restore vs. keep. When there is no borrow the
    // difference is below the divisor, so its low NB_DATA bits are exact.
    always_comb begin
        shifted = {rem_in, dvd_in[NB_DATA-1]};
        borrow  = (shifted < {1'b0, dsr_in});
        diff    = shifted[NB_DATA-1:0] - dsr_in;
        rem_out = borrow ? shifted[NB_DATA-1:0] : diff;
        dvd_out = {dvd_in[NB_DATA-2:0], ~borrow};
    end
endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Divide-by-zero returns all-ones / dividend with a flag; the signed
// overflow case (most-negative / -1) falls out of unsigned magnitude math.
module divider
    import divider_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    divider_if.slave  bus
);
    localparam int CNT_W = $clog2(NB_DATA);

    logic [1:0]         state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NB_DATA-1:0] rem_reg;      // partial remainder
    logic [NB_DATA-1:0] dvd_reg;      // dividend magnitude, becomes quotient
    logic [NB_DATA-1:0] dsr_reg;      // divisor magnitude
    logic               q_neg_reg;
    logic               r_neg_reg;
    logic               dbz_reg;
    logic               pend_reg;     // fixed-up result waiting to be published
    logic               busy_reg;
    logic               done_reg;
    logic [NB_DATA-1:0] quot_reg;
    logic [NB_DATA-1:0] remo_reg;
    logic               dbz_out_reg;

    logic               a_neg;
    logic               b_neg;
    logic [NB_DATA-1:0] a_mag;
    logic [NB_DATA-1:0] b_mag;
    logic [NB_DATA-1:0] rem_next;
    logic [NB_DATA-1:0] dvd_next;

    // Operand signs and magnitudes as seen at the sampling edge.
    always_comb begin
        a_neg = bus.i_signed & bus.i_dividend[NB_DATA-1];
        b_neg = bus.i_signed & bus.i_divisor[NB_DATA-1];
        a_mag = a_neg ? (~bus.i_dividend + 1'b1) : bus.i_dividend;
        b_mag = b_neg ? (~bus.i_divisor + 1'b1) : bus.i_divisor;
    end

    divider_step #(.NB_DATA(NB_DATA)) u_step (
        .rem_in  (rem_reg),
        .dvd_in  (dvd_reg),
        .dsr_in  (dsr_reg),
        .rem_out (rem_next),
        .dvd_out (dvd_next)
    );

    // Control FSM and datapath. FIXUP corrects the signs in place; the
    // following edge publishes the result together with the o_done pulse so
    // the outputs never change ahead of o_done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            q_neg_reg   <= 1'b0;
            r_neg_reg   <= 1'b0;
            dbz_reg     <= 1'b0;
            pend_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            quot_reg    <= '0;
            remo_reg    <= '0;
            dbz_out_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pend_reg) begin
                        quot_reg    <= dvd_reg;
                        remo_reg    <= rem_reg;
                        dbz_out_reg <= dbz_reg;
                        done_reg    <= 1'b1;
                        busy_reg    <= 1'b0;
                        pend_reg    <= 1'b0;
                    end else if (bus.i_start && !busy_reg) begin
                        busy_reg <= 1'b1;
                        if (bus.i_divisor == '0) begin
                            dbz_reg   <= 1'b1;
                            dvd_reg   <= bus.i_dividend;
                            state_reg <= S_FIXUP;
                        end else begin
                            dbz_reg   <= 1'b0;
                            dvd_reg   <= a_mag;
                            dsr_reg   <= b_mag;
                            rem_reg   <= '0;
                            q_neg_reg <= a_neg ^ b_neg;
                            r_neg_reg <= a_neg;
                            cnt_reg   <= CNT_W'(NB_DATA - 1);
                            state_reg <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_reg <= rem_next;
                    dvd_reg <= dvd_next;
                    if (cnt_reg == '0) begin
                        state_reg <= S_FIXUP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_FIXUP: begin
                    if (dbz_reg) begin
                        dvd_reg <= '1;
                        rem_reg <= dvd_reg;
                    end else begin
                        dvd_reg <= q_neg_reg ? (~dvd_reg + 1'b1) : dvd_reg;
                        rem_reg <= r_neg_reg ? (~rem_reg + 1'b1) : rem_reg;
                    end
                    pend_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy        = busy_reg;
    assign bus.o_done        = done_reg;
    assign bus.o_quotient    = quot_reg;
    assign bus.o_remainder   = remo_reg;
    assign bus.o_div_by_zero = dbz_out_reg;
endmodule

// File: tb/tb_divider.sv
// Testbench for divider: directed corner cases plus random operands checked
// against an arithmetic reference model; one line per transaction.
module tb_divider;
    localparam int NB = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    divider_if #(.NB_DATA(NB)) bus ();

    divider #(.NB_DATA(NB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: language division operators plus the RISC-V M special cases.
    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        dz = (b == 32'd0);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endfunction

    // Called between clock edges; returns #1 after the sampling edge.
    task automatic drive_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bus.i_start    = 1'b1;
        bus.i_signed   = sgn;
        bus.i_dividend = a;
        bus.i_divisor  = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        while (bus.o_done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic sgn, input logic [31:0] a,
                                input logic [31:0] b, input int lat);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        ref_div(sgn, a, b, q, r, dz);
        check_val({tag, ".lat"}, lat, (b == 32'd0) ? 32'd2 : 32'd34);
        check_val({tag, ".busy_at_done"}, {31'd0, bus.o_busy}, 32'd0);
        check_val({tag, ".quot"}, bus.o_quotient, q);
        check_val({tag, ".rem"}, bus.o_remainder, r);
        check_val({tag, ".dbz"}, {31'd0, bus.o_div_by_zero}, {31'd0, dz});
        $display("op %s sgn=%0d 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dbz=%0d lat=%0d",
                 tag, sgn, a, b, bus.o_quotient, bus.o_remainder, bus.o_div_by_zero, lat);
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(negedge clk);
        drive_start(sgn, a, b);
        check_val({tag, ".busy"}, {31'd0, bus.o_busy}, 32'd1);
        wait_done(0, lat);
        check_result(tag, sgn, a, b, lat);
        @(posedge clk);
        #1;
        check_val({tag, ".pulse"}, {31'd0, bus.o_done}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          done_seen;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;

        bus.i_start    = 1'b0;
        bus.i_signed   = 1'b0;
        bus.i_dividend = '0;
        bus.i_divisor  = '0;

        // Reset state
        #1;
        check_val("rst.busy", {31'd0, bus.o_busy}, 32'd0);
        check_val("rst.done", {31'd0, bus.o_done}, 32'd0);
        check_val("rst.quot", bus.o_quotient, 32'd0);
        check_val("rst.rem", bus.o_remainder, 32'd0);
        check_val("rst.dbz", {31'd0, bus.o_div_by_zero}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("u100_7", 1'b0, 32'd100, 32'd7);
        run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
        run_op("s5_0", 1'b1, 32'd5, 32'd0);
        run_op("u5_0", 1'b0, 32'd5, 32'd0);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE);

        // Start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (i == 9) begin
                bus.i_start    = 1'b1;
                bus.i_signed   = 1'b0;
                bus.i_dividend = 32'd9;
                bus.i_divisor  = 32'd3;
            end else if (i == 10) begin
                bus.i_start = 1'b0;
            end
        end
        wait_done(lat, lat);
        check_result("ignore", 1'b0, 32'd100, 32'd7, lat);
        drive_start(1'b1, 32'hFFFF_FFF9, 32'd2);
        check_val("b2b.busy", {31'd0, bus.o_busy}, 32'd1);
        wait_done(0, lat);
        check_result("b2b", 1'b1, 32'hFFFF_FFF9, 32'd2, lat);

        // Reset mid-operation aborts immediately with no o_done
        @(negedge clk);
        drive_start(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort.busy", {31'd0, bus.o_busy}, 32'd0);
        check_val("abort.done", {31'd0, bus.o_done}, 32'd0);
        check_val("abort.quot", bus.o_quotient, 32'd0);
        check_val("abort.rem", bus.o_remainder, 32'd0);
        check_val("abort.dbz", {31'd0, bus.o_div_by_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) done_seen++;
        end
        check_val("abort.no_done", done_seen, 32'd0);
        $display("op abort: reset at cycle 10, done pulses afterwards=%0d", done_seen);
        run_op("u9_3", 1'b0, 32'd9, 32'd3);

        // Random operands
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_op($sformatf("rnd%0d", i), sgn, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
